caravel_ext_bus: RTL and testbench

CARAVEL_EXT_BUS -- requirements
Module: caravel

---
 rtl/caravel_ext_bus_pkg.sv | 25 ++
 rtl/ext_bus_parity.sv | 10 +
 rtl/caravel_ext_bus.sv | 181 ++++++++++++++++++
 tb/tb_caravel_ext_bus.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/caravel_ext_bus_pkg.sv
// caravel_ext_bus_pkg: shared frame codes, byte counts and master FSM states.
// Used by caravel_ext_bus and ext_bus_parity; no ports.
package caravel_ext_bus_pkg;

    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] CMD_WR = 8'h03;
    localparam logic [7:0] ACK_RD = 8'h82;
    localparam logic [7:0] ACK_WR = 8'h83;
    localparam logic [7:0] IDLE_BYTE = 8'h00;

    localparam int ADDR_BYTES = 4;
    localparam int DATA_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_ADDR,
        SEND_SEL,
        SEND_DATA,
        WAIT_ACK,
        RECV_DATA,
        DONE
    } state_t;

endpackage

// File: rtl/ext_bus_parity.sv
// ext_bus_parity: odd-parity bit for one bus byte (9-bit word has odd weight).
// Ports: data_i byte in, pty_o parity bit out.
module ext_bus_parity (
    input  logic [7:0] data_i,
    output logic       pty_o
);

    always_comb pty_o = ~^data_i;

endmodule

// File: rtl/caravel_ext_bus.sv
// caravel_ext_bus: Wishbone classic slave bridged to a byte-wide external bus at clk/2.
// Ports: clk/rst, wb_* Wishbone slave, ext_bus_clk/out/pty_out to the external slave,
// ext_bus_in/pty_in from it, bus_error sticky parity/protocol error flag.
module caravel_ext_bus
    import caravel_ext_bus_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [31:0] wb_adr,
    input  logic [63:0] wb_dat_w,
    input  logic [7:0]  wb_sel,
    output logic [63:0] wb_dat_r,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        ext_bus_clk,
    output logic [7:0]  ext_bus_out,
    output logic        ext_bus_pty_out,
    input  logic [7:0]  ext_bus_in,
    input  logic        ext_bus_pty_in,
    output logic        bus_error
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_t        state_q;
    logic          bclk_q;
    logic [7:0]    out_q;
    logic          we_q;
    logic [31:0]   adr_q;
    logic [7:0]    sel_q;
    logic [63:0]   dat_q;
    logic [63:0]   rdat_q;
    logic [2:0]    cnt_q;
    logic [TW-1:0] tmr_q;
    logic          ack_q;
    logic          err_q;
    logic          berr_q;
    logic          drop_q;
    logic          rx_pty;
    logic          rx_bad;
    logic          fall;
    logic          rise;
    logic          fin_ok;
    logic [7:0]    exp_ack;

    ext_bus_parity u_tx_pty (.data_i(out_q),      .pty_o(ext_bus_pty_out));
    ext_bus_parity u_rx_pty (.data_i(ext_bus_in), .pty_o(rx_pty));

    // bclk_q high means this edge drives the bus clock low (transmit edge),
    // low means this edge drives it high (receive sample edge).
    assign fall    = bclk_q;
    assign rise    = !bclk_q;
    assign rx_bad  = ext_bus_pty_in != rx_pty;
    assign exp_ack = we_q ? ACK_WR : ACK_RD;
    // A completion is reported only if the master kept the cycle open throughout.
    assign fin_ok  = wb_cyc && !drop_q;

    assign ext_bus_clk = bclk_q;
    assign ext_bus_out = out_q;
    assign wb_dat_r    = rdat_q;
    assign wb_ack      = ack_q;
    assign wb_err      = err_q;
    assign bus_error   = berr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bclk_q  <= 1'b0;
            out_q   <= IDLE_BYTE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            rdat_q  <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            berr_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            bclk_q <= !bclk_q;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            if (state_q != IDLE && !wb_cyc)
                drop_q <= 1'b1;
            case (state_q)
                IDLE: if (fall && wb_cyc && wb_stb) begin
                    we_q    <= wb_we;
                    adr_q   <= wb_adr;
                    sel_q   <= wb_sel;
                    dat_q   <= wb_dat_w;
                    drop_q  <= 1'b0;
                    out_q   <= wb_we ? CMD_WR : CMD_RD;
                    state_q <= SEND_CMD;
                end
                SEND_CMD: if (fall) begin
                    out_q   <= adr_q[7:0];
                    adr_q   <= adr_q >> 8;
                    cnt_q   <= '0;
                    state_q <= SEND_ADDR;
                end
                SEND_ADDR: if (fall) begin
                    if (cnt_q != 3'(ADDR_BYTES - 1)) begin
                        out_q <= adr_q[7:0];
                        adr_q <= adr_q >> 8;
                        cnt_q <= cnt_q + 3'd1;
                    end else if (we_q) begin
                        out_q   <= sel_q;
                        state_q <= SEND_SEL;
                    end else begin
                        out_q   <= IDLE_BYTE;
                        tmr_q   <= '0;
                        state_q <= WAIT_ACK;
                    end
                end
                SEND_SEL: if (fall) begin
                    out_q   <= dat_q[7:0];
                    dat_q   <= dat_q >> 8;
                    cnt_q   <= '0;
                    state_q <= SEND_DATA;
                end
                SEND_DATA: if (fall) begin
                    if (cnt_q != 3'(DATA_BYTES - 1)) begin
                        out_q <= dat_q[7:0];
                        dat_q <= dat_q >> 8;
                        cnt_q <= cnt_q + 3'd1;
                    end else begin
                        out_q   <= IDLE_BYTE;
                        tmr_q   <= '0;
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: if (rise) begin
                    if (ext_bus_in == IDLE_BYTE) begin
                        // Idle bytes are ignored but count towards the timeout.
                        if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                            err_q   <= fin_ok;
                            state_q <= DONE;
                        end else begin
                            tmr_q <= tmr_q + TW'(1);
                        end
                    end else if (rx_bad || ext_bus_in != exp_ack) begin
                        berr_q  <= 1'b1;
                        err_q   <= fin_ok;
                        state_q <= DONE;
                    end else if (we_q) begin
                        ack_q   <= fin_ok;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= RECV_DATA;
                    end
                end
                RECV_DATA: if (rise) begin
                    if (rx_bad) begin
                        berr_q  <= 1'b1;
                        err_q   <= fin_ok;
                        state_q <= DONE;
                    end else begin
                        // Bytes arrive LSB first: shift in from the top.
                        rdat_q <= {ext_bus_in, rdat_q[63:8]};
                        cnt_q  <= cnt_q + 3'd1;
                        if (cnt_q == 3'(DATA_BYTES - 1)) begin
                            ack_q   <= fin_ok;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_caravel_ext_bus.sv
// tb_caravel_ext_bus: directed checks of the caravel_ext_bus frame, ack, error and reset behaviour.
module tb_caravel_ext_bus;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [31:0] wb_adr = '0;
    logic [63:0] wb_dat_w = '0;
    logic [7:0]  wb_sel = '0;
    logic [63:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_err;
    logic        ext_bus_clk;
    logic [7:0]  ext_bus_out;
    logic        ext_bus_pty_out;
    logic [7:0]  ext_bus_in = '0;
    logic        ext_bus_pty_in = 1'b1;
    logic        bus_error;

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  mon[$];
    logic [7:0]  last_out = '0;
    logic        a;
    logic        e;
    int          n;

    localparam logic [71:0] RD_RSP = {8'h82, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

    caravel_ext_bus #(.ACK_TIMEOUT(32)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_dat_r(wb_dat_r),
        .wb_ack(wb_ack), .wb_err(wb_err),
        .ext_bus_clk(ext_bus_clk), .ext_bus_out(ext_bus_out), .ext_bus_pty_out(ext_bus_pty_out),
        .ext_bus_in(ext_bus_in), .ext_bus_pty_in(ext_bus_pty_in), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Record every byte on the bus and check its parity.
    always @(negedge ext_bus_clk) begin
        #1;
        mon.push_back(ext_bus_out);
        last_out = ext_bus_out;
        chk("tx_pty", 64'(ext_bus_pty_out), 64'(~^ext_bus_out));
    end

    // Output byte must not move on the rising bus-clock edge.
    always @(posedge ext_bus_clk) begin
        #1;
        chk("tx_hold", 64'(ext_bus_out), 64'(last_out));
    end

    task automatic req(input logic we, input logic [31:0] adr, input logic [7:0] sel, input logic [63:0] dat);
        @(posedge clk);
        #1;
        wb_we = we;
        wb_adr = adr;
        wb_sel = sel;
        wb_dat_w = dat;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
    endtask

    task automatic slave(input int dly, input logic [71:0] bytes, input int cnt, input int bad);
        logic [7:0] b;
        repeat (dly) @(negedge ext_bus_clk);
        for (int k = 0; k < cnt; k++) begin
            #1;
            b = bytes[8*(cnt-1-k) +: 8];
            ext_bus_in = b;
            ext_bus_pty_in = (~^b) ^ (k == bad);
            @(negedge ext_bus_clk);
        end
        #1;
        ext_bus_in = 8'h00;
        ext_bus_pty_in = 1'b1;
    endtask

    task automatic wait_done(output logic ga, output logic ge, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!(wb_ack || wb_err) && cyc < 400);
        if (cyc >= 400) chk("done_timeout", 64'(cyc), 64'(0));
        ga = wb_ack;
        ge = wb_err;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        @(posedge clk);
        #1;
        chk("pulse_width", {62'b0, wb_ack, wb_err}, 64'(0));
    endtask

    task automatic chk_frame(input logic [119:0] exp, input int cnt);
        int i;
        logic [7:0] got;
        i = 0;
        while (i < mon.size() && mon[i] == 8'h00) i++;
        if (i >= mon.size()) chk("frame_start", 64'(0), 64'(1));
        for (int k = 0; k < cnt; k++) begin
            got = (i + k < mon.size()) ? mon[i+k] : 8'hxx;
            chk($sformatf("frame[%0d]", k), 64'(got), 64'(exp[8*(cnt-1-k) +: 8]));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bclk", 64'(ext_bus_clk), 64'(0));
        chk("rst_out", 64'(ext_bus_out), 64'(0));
        chk("rst_pty", 64'(ext_bus_pty_out), 64'(1));
        chk("rst_ack", 64'(wb_ack), 64'(0));
        chk("rst_err", 64'(wb_err), 64'(0));
        chk("rst_datr", wb_dat_r, 64'(0));
        chk("rst_berr", 64'(bus_error), 64'(0));
        rst = 1'b0;

        // Write with ack.
        mon.delete();
        req(1'b1, 32'h0000_1000, 8'hFF, 64'h1122_3344_5566_7788);
        fork
            slave(20, 72'h83, 1, -1);
            wait_done(a, e, n);
        join
        chk("wr_ack", 64'(a), 64'(1));
        chk("wr_err", 64'(e), 64'(0));
        chk("wr_berr", 64'(bus_error), 64'(0));
        chk_frame({8'h03, 8'h00, 8'h10, 8'h00, 8'h00, 8'hFF, 8'h88, 8'h77,
                   8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00}, 15);

        // Read with delayed ack and data.
        mon.delete();
        req(1'b0, 32'h0000_2000, 8'hFF, 64'h0);
        fork
            slave(14, RD_RSP, 9, -1);
            wait_done(a, e, n);
        join
        chk("rd_ack", 64'(a), 64'(1));
        chk("rd_err", 64'(e), 64'(0));
        chk("rd_data", wb_dat_r, 64'h0102_0304_0506_0708);
        chk_frame({8'h02, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00}, 6);

        // Silent slave: timeout.
        req(1'b0, 32'h0000_3000, 8'hFF, 64'h0);
        wait_done(a, e, n);
        chk("to_err", 64'(e), 64'(1));
        chk("to_ack", 64'(a), 64'(0));
        chk("to_lat_ok", 64'(n >= 70 && n <= 80), 64'(1));
        chk("to_out", 64'(ext_bus_out), 64'(0));

        // Corrupted parity on a read data byte.
        req(1'b0, 32'h0000_4000, 8'hFF, 64'h0);
        fork
            slave(10, RD_RSP, 9, 3);
            wait_done(a, e, n);
        join
        chk("pty_err", 64'(e), 64'(1));
        chk("pty_ack", 64'(a), 64'(0));
        chk("pty_berr", 64'(bus_error), 64'(1));

        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("berr_clr", 64'(bus_error), 64'(0));

        // Bad reply code.
        req(1'b0, 32'h0000_4400, 8'hFF, 64'h0);
        fork
            slave(8, 72'h55, 1, -1);
            wait_done(a, e, n);
        join
        chk("bad_err", 64'(e), 64'(1));
        chk("bad_ack", 64'(a), 64'(0));
        chk("bad_berr", 64'(bus_error), 64'(1));

        // Reset in the middle of a write frame.
        req(1'b1, 32'h0000_1000, 8'hFF, 64'h1122_3344_5566_7788);
        repeat (6) @(negedge ext_bus_clk);
        @(posedge ext_bus_clk);
        #3;
        rst = 1'b1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        #2;
        chk("mid_out", 64'(ext_bus_out), 64'(0));
        chk("mid_mon", 64'(mon[mon.size()-1]), 64'(0));
        chk("mid_berr", 64'(bus_error), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon.delete();
        req(1'b0, 32'h0000_5000, 8'hFF, 64'h0);
        fork
            slave(14, {8'h82, 8'hF8, 8'hE7, 8'hD6, 8'hC5, 8'hB4, 8'hA3, 8'h92, 8'h81}, 9, -1);
            wait_done(a, e, n);
        join
        chk("post_ack", 64'(a), 64'(1));
        chk("post_data", wb_dat_r, 64'h8192_A3B4_C5D6_E7F8);
        chk_frame({8'h02, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00}, 6);

        // Master abandons the cycle: frame completes, no completion pulse.
        mon.delete();
        req(1'b0, 32'h0000_6000, 8'hFF, 64'h0);
        fork
            slave(14, RD_RSP, 9, -1);
            begin
                int p;
                p = 0;
                repeat (3) @(negedge ext_bus_clk);
                #1;
                wb_cyc = 1'b0;
                wb_stb = 1'b0;
                repeat (80) begin
                    @(posedge clk);
                    #1;
                    if (wb_ack || wb_err) p++;
                end
                chk("drop_nopulse", 64'(p), 64'(0));
            end
        join
        chk_frame({8'h02, 8'h00, 8'h60, 8'h00, 8'h00, 8'h00}, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
